// File: rtl/src_control_unit_if.sv
// Control bundle between the SRC sequencer and its datapath: opcode, branch
// flag and memory handshake in; bus-driver, register-load, ALU and memory
// request strobes out.
interface src_control_unit_if #(
    parameter int ALU_W = 4
);
    logic [4:0]       opcode;
    logic             con;
    logic             mem_done;

    logic             pc_out, c1_out, c2_out, md_out, c_out, r_out, ba_out;
    logic             pc_in, ma_in, md_in, ir_in, a_in, c_in, r_in, con_in;
    logic             gra, grb, grc;
    logic [ALU_W-1:0] alu_op;
    logic             read, write;
    logic             halt, illegal;

    modport master (
        input  opcode, con, mem_done,
        output pc_out, c1_out, c2_out, md_out, c_out, r_out, ba_out,
        output pc_in, ma_in, md_in, ir_in, a_in, c_in, r_in, con_in,
        output gra, grb, grc, alu_op, read, write, halt, illegal
    );

    modport slave (
        output opcode, con, mem_done,
        input  pc_out, c1_out, c2_out, md_out, c_out, r_out, ba_out,
        input  pc_in, ma_in, md_in, ir_in, a_in, c_in, r_in, con_in,
        input  gra, grb, grc, alu_op, read, write, halt, illegal
    );
endinterface

// File: rtl/src_control_unit.sv
// Hard-wired Moore sequencer for the single-bus SRC CPU. Runs fetch
// (FETCH0..FETCH2) then an opcode-dependent execute sequence (EXEC with a
// step counter), forever, until a stop opcode parks it in HALT.
module src_control_unit #(
    parameter int ALU_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    src_control_unit_if.master  bus
);
    typedef enum logic [2:0] {FETCH0, FETCH1, FETCH2, EXEC, HALT} state_t;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_LD   = 5'd1;
    localparam logic [4:0] OP_LDR  = 5'd2;
    localparam logic [4:0] OP_ST   = 5'd3;
    localparam logic [4:0] OP_LA   = 5'd5;
    localparam logic [4:0] OP_LAR  = 5'd6;
    localparam logic [4:0] OP_BR   = 5'd8;
    localparam logic [4:0] OP_ADD  = 5'd12;
    localparam logic [4:0] OP_ADDI = 5'd13;
    localparam logic [4:0] OP_SUB  = 5'd14;
    localparam logic [4:0] OP_AND  = 5'd20;
    localparam logic [4:0] OP_OR   = 5'd22;
    localparam logic [4:0] OP_NOT  = 5'd24;
    localparam logic [4:0] OP_STOP = 5'd31;

    localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_NOT  = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_INC4 = ALU_W'(6);

    state_t     state;
    logic [2:0] step;
    logic       run;    // low during reset and the release cycle, so all strobes stay 0
    logic       first;  // first cycle of FETCH1: the only cycle pc_in is allowed
    logic       mem_wait;

    // Final execute step of each opcode; unknown opcodes take a single step.
    function automatic logic [2:0] last_step(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR, OP_LA, OP_LAR: last_step = 3'd2;
            OP_NOT, OP_BR:                                         last_step = 3'd1;
            OP_LD, OP_LDR, OP_ST:                                  last_step = 3'd4;
            default:                                               last_step = 3'd0;
        endcase
    endfunction

    // ALU operation for the two-operand register instructions.
    function automatic logic [ALU_W-1:0] alu_sel(input logic [4:0] op);
        case (op)
            OP_SUB:  alu_sel = ALU_SUB;
            OP_AND:  alu_sel = ALU_AND;
            OP_OR:   alu_sel = ALU_OR;
            default: alu_sel = ALU_ADD;
        endcase
    endfunction

    // A memory request is outstanding whenever read or write is being driven.
    assign mem_wait = bus.read | bus.write;

    // Sequencer state: fetch, execute steps, memory waits and halt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH0;
            step  <= 3'd0;
            run   <= 1'b0;
            first <= 1'b0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            case (state)
                FETCH0: begin
                    state <= FETCH1;
                    first <= 1'b1;
                end
                FETCH1: begin
                    first <= 1'b0;
                    if (bus.mem_done) state <= FETCH2;
                end
                FETCH2: begin
                    state <= EXEC;
                    step  <= 3'd0;
                end
                EXEC: begin
                    if (bus.opcode == OP_STOP)          state <= HALT;
                    else if (mem_wait && !bus.mem_done) state <= EXEC;
                    else if (step == last_step(bus.opcode)) state <= FETCH0;
                    else                                step  <= step + 3'd1;
                end
                HALT:    state <= HALT;
                default: state <= FETCH0;
            endcase
        end
    end

    // Strobe decode from registered state, step and the latched opcode/flag.
    always_comb begin
        bus.pc_out = 1'b0; bus.c1_out = 1'b0; bus.c2_out = 1'b0; bus.md_out = 1'b0;
        bus.c_out  = 1'b0; bus.r_out  = 1'b0; bus.ba_out = 1'b0;
        bus.pc_in  = 1'b0; bus.ma_in  = 1'b0; bus.md_in  = 1'b0; bus.ir_in  = 1'b0;
        bus.a_in   = 1'b0; bus.c_in   = 1'b0; bus.r_in   = 1'b0; bus.con_in = 1'b0;
        bus.gra    = 1'b0; bus.grb    = 1'b0; bus.grc    = 1'b0;
        bus.alu_op = '0;
        bus.read   = 1'b0; bus.write  = 1'b0;
        bus.halt   = 1'b0; bus.illegal = 1'b0;
        if (run) begin
            case (state)
                FETCH0: begin
                    bus.pc_out = 1'b1; bus.ma_in = 1'b1;
                    bus.alu_op = ALU_INC4; bus.c_in = 1'b1;
                end
                FETCH1: begin
                    bus.c_out = 1'b1; bus.read = 1'b1; bus.pc_in = first;
                end
                FETCH2: begin
                    bus.md_out = 1'b1; bus.ir_in = 1'b1;
                end
                EXEC: begin
                    case (bus.opcode)
                        OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR: begin
                            case (step)
                                3'd0: begin bus.grb = 1'b1; bus.r_out = 1'b1; bus.a_in = 1'b1; end
                                3'd1: begin
                                    bus.alu_op = alu_sel(bus.opcode); bus.c_in = 1'b1;
                                    if (bus.opcode == OP_ADDI) bus.c2_out = 1'b1;
                                    else begin bus.grc = 1'b1; bus.r_out = 1'b1; end
                                end
                                3'd2: begin bus.c_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1; end
                                default: ;
                            endcase
                        end
                        OP_NOT: begin
                            if (step == 3'd0) begin
                                bus.grc = 1'b1; bus.r_out = 1'b1;
                                bus.alu_op = ALU_NOT; bus.c_in = 1'b1;
                            end else begin
                                bus.c_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1;
                            end
                        end
                        OP_LA, OP_LAR, OP_LD, OP_LDR, OP_ST: begin
                            case (step)
                                3'd0: begin
                                    bus.a_in = 1'b1;
                                    if (bus.opcode == OP_LAR || bus.opcode == OP_LDR) bus.pc_out = 1'b1;
                                    else begin bus.grb = 1'b1; bus.ba_out = 1'b1; end
                                end
                                3'd1: begin
                                    bus.alu_op = ALU_ADD; bus.c_in = 1'b1;
                                    if (bus.opcode == OP_LAR || bus.opcode == OP_LDR) bus.c1_out = 1'b1;
                                    else bus.c2_out = 1'b1;
                                end
                                3'd2: begin
                                    bus.c_out = 1'b1;
                                    if (bus.opcode == OP_LA || bus.opcode == OP_LAR) begin
                                        bus.gra = 1'b1; bus.r_in = 1'b1;
                                    end else bus.ma_in = 1'b1;
                                end
                                3'd3: begin
                                    if (bus.opcode == OP_ST) begin
                                        bus.gra = 1'b1; bus.r_out = 1'b1; bus.md_in = 1'b1;
                                    end else bus.read = 1'b1;
                                end
                                3'd4: begin
                                    if (bus.opcode == OP_ST) bus.write = 1'b1;
                                    else begin bus.md_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1; end
                                end
                                default: ;
                            endcase
                        end
                        OP_BR: begin
                            if (step == 3'd0) begin
                                bus.grc = 1'b1; bus.r_out = 1'b1; bus.con_in = 1'b1;
                            end else begin
                                bus.grb = 1'b1; bus.r_out = 1'b1; bus.pc_in = bus.con;
                            end
                        end
                        OP_NOP, OP_STOP: ;
                        default: bus.illegal = (step == 3'd0);
                    endcase
                end
                HALT:    bus.halt = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_src_control_unit.sv
// Bench for src_control_unit: builds the expected strobe stream of each
// instruction from the instruction-level transfer table, drives opcode, con
// and mem_done from that same schedule, and compares every cycle.
module tb_src_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    src_control_unit_if #(.ALU_W(4)) bus ();
    src_control_unit #(.ALU_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Bit positions of the packed strobe word; alu_op sits in [27:24].
    localparam logic [31:0] PC_OUT = 32'd1 << 0,  C1_OUT = 32'd1 << 1,  C2_OUT = 32'd1 << 2;
    localparam logic [31:0] MD_OUT = 32'd1 << 3,  C_OUT  = 32'd1 << 4,  R_OUT  = 32'd1 << 5;
    localparam logic [31:0] BA_OUT = 32'd1 << 6,  PC_IN  = 32'd1 << 7,  MA_IN  = 32'd1 << 8;
    localparam logic [31:0] MD_IN  = 32'd1 << 9,  IR_IN  = 32'd1 << 10, A_IN   = 32'd1 << 11;
    localparam logic [31:0] C_IN   = 32'd1 << 12, R_IN   = 32'd1 << 13, CON_IN = 32'd1 << 14;
    localparam logic [31:0] GRA    = 32'd1 << 15, GRB    = 32'd1 << 16, GRC    = 32'd1 << 17;
    localparam logic [31:0] READ   = 32'd1 << 18, WRITE  = 32'd1 << 19, HALT   = 32'd1 << 20;
    localparam logic [31:0] ILLEGAL = 32'd1 << 21;

    logic [31:0] exp_q[$];
    bit          md_q[$];
    logic [4:0]  op_q[$];
    bit          con_q[$];
    logic [4:0]  cur_op;
    bit          cur_con;
    int          cyc = 0;

    function automatic logic [31:0] alu(input int code);
        return 32'(code) << 24;
    endfunction

    function automatic logic [31:0] observed();
        return {4'b0, bus.alu_op, 2'b0, bus.illegal, bus.halt, bus.write, bus.read,
                bus.grc, bus.grb, bus.gra, bus.con_in, bus.r_in, bus.c_in, bus.a_in,
                bus.ir_in, bus.md_in, bus.ma_in, bus.pc_in, bus.ba_out, bus.r_out,
                bus.c_out, bus.md_out, bus.c2_out, bus.c1_out, bus.pc_out};
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    // One expected cycle with an explicit mem_done value.
    task automatic push(input logic [31:0] v, input bit md);
        exp_q.push_back(v); md_q.push_back(md);
        op_q.push_back(cur_op); con_q.push_back(cur_con);
    endtask

    // A cycle with no memory request: mem_done is random noise there.
    task automatic pushn(input logic [31:0] v);
        push(v, 1'($urandom_range(0, 1)));
    endtask

    // A memory wait of 'lat' cycles; mem_done arrives on the last one.
    task automatic push_wait(input logic [31:0] v, input int lat);
        for (int i = 0; i < lat; i++) push(v, i == lat - 1);
    endtask

    // Register-transfer schedule of one complete instruction.
    task automatic gen_instr(input logic [4:0] op, input bit c, input int lf, input int le);
        bit rel;
        cur_op = op; cur_con = c;
        pushn(PC_OUT | MA_IN | C_IN | alu(6));
        for (int i = 0; i < lf; i++) push(C_OUT | READ | ((i == 0) ? PC_IN : 32'd0), i == lf - 1);
        pushn(MD_OUT | IR_IN);
        rel = (op == 5'd2 || op == 5'd6);
        case (op)
            5'd12, 5'd13, 5'd14, 5'd20, 5'd22: begin
                pushn(GRB | R_OUT | A_IN);
                pushn(((op == 5'd13) ? C2_OUT : (GRC | R_OUT)) | C_IN |
                      alu((op == 5'd14) ? 2 : (op == 5'd20) ? 3 : (op == 5'd22) ? 4 : 1));
                pushn(C_OUT | GRA | R_IN);
            end
            5'd24: begin
                pushn(GRC | R_OUT | C_IN | alu(5));
                pushn(C_OUT | GRA | R_IN);
            end
            5'd1, 5'd2, 5'd3, 5'd5, 5'd6: begin
                pushn(rel ? (PC_OUT | A_IN) : (GRB | BA_OUT | A_IN));
                pushn((rel ? C1_OUT : C2_OUT) | C_IN | alu(1));
                if (op == 5'd5 || op == 5'd6) pushn(C_OUT | GRA | R_IN);
                else begin
                    pushn(C_OUT | MA_IN);
                    if (op == 5'd3) begin
                        pushn(GRA | R_OUT | MD_IN);
                        push_wait(WRITE, le);
                    end else begin
                        push_wait(READ, le);
                        pushn(MD_OUT | GRA | R_IN);
                    end
                end
            end
            5'd8: begin
                pushn(GRC | R_OUT | CON_IN);
                pushn(GRB | R_OUT | (c ? PC_IN : 32'd0));
            end
            5'd0, 5'd31: pushn(32'd0);
            default: pushn(ILLEGAL);
        endcase
    endtask

    // Drive and check n cycles from the expectation queues.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.mem_done = md_q.pop_front();
            bus.opcode   = op_q.pop_front();
            bus.con      = con_q.pop_front();
            #1;
            chk_eq($sformatf("cyc%0d", cyc), observed(), exp_q.pop_front());
            cyc++;
        end
    endtask

    task automatic run_all();
        run_cycles(exp_q.size());
    endtask

    task automatic clear_q();
        exp_q.delete(); md_q.delete(); op_q.delete(); con_q.delete();
    endtask

    logic [4:0] op_tab [15] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd8, 5'd12,
                                5'd13, 5'd14, 5'd20, 5'd22, 5'd24, 5'd7, 5'd9};

    initial begin
        bus.opcode = 5'd0; bus.con = 1'b0; bus.mem_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("reset", observed(), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed: add, fetch with 3-cycle delay, ld/st with 2-cycle memory,
        // br both ways, illegal opcode, then every other instruction.
        gen_instr(5'd12, 1'b0, 1, 1);
        gen_instr(5'd14, 1'b0, 4, 1);
        gen_instr(5'd1,  1'b0, 2, 2);
        gen_instr(5'd3,  1'b0, 2, 2);
        gen_instr(5'd8,  1'b0, 1, 1);
        gen_instr(5'd8,  1'b1, 1, 1);
        gen_instr(5'd7,  1'b1, 1, 1);
        gen_instr(5'd0,  1'b0, 1, 1);
        gen_instr(5'd24, 1'b0, 1, 1);
        gen_instr(5'd13, 1'b0, 1, 1);
        gen_instr(5'd5,  1'b0, 1, 1);
        gen_instr(5'd6,  1'b0, 1, 1);
        gen_instr(5'd2,  1'b0, 3, 1);
        gen_instr(5'd20, 1'b0, 1, 1);
        gen_instr(5'd22, 1'b0, 1, 1);
        run_all();

        // Random instruction mix with random branch flag and memory latency.
        for (int k = 0; k < 60; k++)
            gen_instr(op_tab[$urandom_range(0, 14)], 1'($urandom_range(0, 1)),
                      $urandom_range(1, 4), $urandom_range(1, 4));
        run_all();

        // Reset asserted during the first E3 cycle of ld while read is high.
        clear_q();
        gen_instr(5'd1, 1'b0, 1, 3);
        run_cycles(7);
        chk_eq("ld_e3_read", observed() & READ, READ);
        #2 rst = 1'b0;
        #1 chk_eq("rst_async", observed(), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        clear_q();
        gen_instr(5'd12, 1'b0, 1, 1);
        run_all();

        // stop parks the sequencer: halt only, for 20 cycles.
        gen_instr(5'd31, 1'b0, 1, 1);
        for (int i = 0; i < 20; i++) pushn(HALT);
        run_all();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
